reverse_ctrl: RTL and testbench

- FSM controller that sequences the reverse-number datapath (regX / regRE / regO, mux select, x==0 compare).
- Accepts a start pulse and loads the operand.
- Iterates re <= re*10 + x%10 and x <= x/10 until x==0, then commits re to the output register.
- Reports completion with a done pulse, an error pulse or abort; sits between the system bus/testbench and the datapath in the reverse-number top level.

---
 rtl/reverse_ctrl.sv | 97 +++++++++
 tb/tb_reverse_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reverse_ctrl.sv
// reverse_ctrl: Moore FSM sequencing the reverse-number datapath (load, iterate, commit, error cap, abort).
module reverse_ctrl #(
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             x_eq,
    output logic             st,
    output logic             ld_x,
    output logic             ld_re,
    output logic             ld_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] digit_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_STEP,
        S_OUTPUT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             st_q, st_d;
    logic             ld_x_q, ld_x_d;
    logic             ld_re_q, ld_re_d;
    logic             ld_out_q, ld_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Next state with abort override; outputs decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_INIT : S_IDLE;
            S_INIT:   state_d = S_CHECK;
            S_CHECK:  state_d = x_eq ? S_OUTPUT : (cnt_q == CNT_W'(MAX_DIGITS)) ? S_ERR : S_STEP;
            S_STEP:   state_d = S_CHECK;
            S_OUTPUT: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
        cnt_d    = (state_q == S_INIT) ? '0 : (state_q == S_STEP) ? cnt_q + 1'b1 : cnt_q;
        st_d     = state_d == S_STEP;
        ld_x_d   = state_d == S_INIT || state_d == S_STEP;
        ld_re_d  = state_d == S_INIT || state_d == S_STEP;
        ld_out_d = state_d == S_OUTPUT;
        busy_d   = state_d != S_IDLE;
        done_d   = state_d == S_DONE;
        err_d    = state_d == S_ERR;
    end

    // State, digit counter and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            st_q     <= 1'b0;
            ld_x_q   <= 1'b0;
            ld_re_q  <= 1'b0;
            ld_out_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            ld_x_q   <= ld_x_d;
            ld_re_q  <= ld_re_d;
            ld_out_q <= ld_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign st        = st_q;
    assign ld_x      = ld_x_q;
    assign ld_re     = ld_re_q;
    assign ld_out    = ld_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_reverse_ctrl.sv
// tb_reverse_ctrl: scoreboard bench for reverse_ctrl driving a behavioural reverse-number datapath.
module tb_reverse_ctrl;

    typedef struct {
        int          dut;
        bit          is_err;
        int          cyc;
        logic [15:0] rev;
        logic [2:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start_v, abort_v, x_eq_v;
    wire  [1:0]  st_v, ld_x_v, ld_re_v, ld_out_v, busy_v, done_v, err_v;
    wire  [2:0]  cnt0, cnt1;
    logic [15:0] xin [2];
    logic [15:0] rx  [2];
    logic [15:0] rre [2];
    logic [15:0] ro  [2];
    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ldout = 0;
    int          snap;

    always #5 clk = ~clk;

    reverse_ctrl #(.MAX_DIGITS(5), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .x_eq(x_eq_v[0]),
        .st(st_v[0]), .ld_x(ld_x_v[0]), .ld_re(ld_re_v[0]), .ld_out(ld_out_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .digit_cnt(cnt0)
    );

    reverse_ctrl #(.MAX_DIGITS(2), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .x_eq(x_eq_v[1]),
        .st(st_v[1]), .ld_x(ld_x_v[1]), .ld_re(ld_re_v[1]), .ld_out(ld_out_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .digit_cnt(cnt1)
    );

    // Datapath model: regX, regRE, regO with 16-bit wrapping arithmetic.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rx[i]  <= '0;
                rre[i] <= '0;
                ro[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ld_x_v[i]) rx[i] <= st_v[i] ? rx[i] / 16'd10 : xin[i];
                if (ld_re_v[i]) rre[i] <= st_v[i] ? 16'(rre[i] * 16'd10 + rx[i] % 16'd10) : 16'd0;
                if (ld_out_v[i]) ro[i] <= rre[i];
            end
        end
    end

    always_comb x_eq_v = {rx[1] == 16'd0, rx[0] == 16'd0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/err pulse pops one expectation and compares it.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (done_v[i] || err_v[i]) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_event: dut%0d done=%b err=%b at cycle %0d, expected none", i, done_v[i], err_v[i], cyc);
                    end else begin
                        e = sb.pop_front();
                        check("event_dut", i, e.dut);
                        check("event_is_err", int'(err_v[i]), int'(e.is_err));
                        check("event_cycle", cyc, e.cyc);
                        check("reverse", int'(ro[i]), int'(e.rev));
                        check("digit_cnt", int'(i == 0 ? cnt0 : cnt1), int'(e.cnt));
                    end
                end
            end
            if (ld_out_v[0]) n_ldout++;
        end
    end

    // Issue one start (optionally with abort in the same IDLE cycle); lat is the event cycle index counted from cycle 0.
    task automatic go(input int i, input logic [15:0] x, input bit ab, input bit ev, input bit is_err,
                      input int lat, input logic [15:0] rev, input logic [2:0] cnt);
        int c0;
        @(negedge clk);
        xin[i]     = x;
        start_v[i] = 1'b1;
        abort_v[i] = ab;
        c0 = cyc + 1;
        if (ev) sb.push_back('{i, is_err, c0 + lat - 1, rev, cnt});
        @(negedge clk);
        start_v[i] = 1'b0;
        abort_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int k = 0;
        while (busy_v[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", int'(busy_v[i]), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        rst = 1'b1;
        start_v = '0;
        abort_v = '0;
        xin[0] = '0;
        xin[1] = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({st_v[0], ld_x_v[0], ld_re_v[0], ld_out_v[0], busy_v[0], done_v[0], err_v[0], cnt0}), 0);
        rst = 1'b0;

        go(0, 16'd12345, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("in_step_before_rst", int'(st_v[0]), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", int'({st_v[0], ld_x_v[0], ld_re_v[0], ld_out_v[0], busy_v[0], done_v[0], err_v[0], cnt0}), 0);
        @(negedge clk);
        rst = 1'b0;
        go(0, 16'd12345, 0, 1, 0, 14, 16'd54321, 3'd5);
        wait_idle(0);

        go(0, 16'd123, 0, 1, 0, 10, 16'd321, 3'd3);
        for (int n = 1; n <= 10; n++) begin
            check("busy_during_op", int'(busy_v[0]), 1);
            @(negedge clk);
        end
        check("busy_after_done", int'(busy_v[0]), 0);
        go(0, 16'd0, 0, 1, 0, 4, 16'd0, 3'd0);
        wait_idle(0);

        go(0, 16'd19999, 0, 1, 0, 14, 16'd34455, 3'd5);
        wait_idle(0);
        go(0, 16'd1200, 0, 1, 0, 12, 16'd21, 3'd4);
        wait_idle(0);

        snap = n_ldout;
        go(0, 16'd4567, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        check("third_step_reached", int'(st_v[0]), 1);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("abort_busy", int'(busy_v[0]), 0);
        check("abort_cnt", int'(cnt0), 3);
        repeat (4) @(negedge clk);
        check("abort_no_ld_out", n_ldout - snap, 0);
        check("abort_regO_kept", int'(ro[0]), 21);
        go(0, 16'd89, 0, 1, 0, 8, 16'd98, 3'd2);
        wait_idle(0);

        go(0, 16'd89, 1, 1, 0, 8, 16'd98, 3'd2);
        check("start_abort_idle_busy", int'(busy_v[0]), 1);
        wait_idle(0);

        @(negedge clk);
        xin[0] = 16'd45;
        start_v[0] = 1'b1;
        c0 = cyc + 1;
        sb.push_back('{0, 1'b0, c0 + 7, 16'd54, 3'd2});
        sb.push_back('{0, 1'b0, c0 + 16, 16'd54, 3'd2});
        repeat (12) @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);

        go(1, 16'd45, 0, 1, 0, 8, 16'd54, 3'd2);
        wait_idle(1);
        go(1, 16'd123, 0, 1, 1, 7, 16'd54, 3'd2);
        wait_idle(1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
